// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: one-cycle decode->execute capture with stall hold and flush/invalid bubbles.
// Optional bubble counter on bubble_count when ID_EX_BUBBLE_COUNT_EN is defined; otherwise tied to zero.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_branch,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_funct,
  output logic [1:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_regdst,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic [31:0]       bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [5:0]        funct;
    logic [1:0]        aluop;
    logic              alusrc;
    logic              regdst;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              regwrite;
  } ex_bus_t;

  ex_bus_t w_id;
  ex_bus_t r_ex;
  logic    w_bubble;

  assign w_id = '{valid: id_valid, pc_plus4: id_pc_plus4, rdata1: id_rdata1,
                  rdata2: id_rdata2, imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd,
                  funct: id_funct, aluop: id_aluop, alusrc: id_alusrc,
                  regdst: id_regdst, branch: id_branch, memread: id_memread,
                  memwrite: id_memwrite, memtoreg: id_memtoreg,
                  regwrite: id_regwrite};

  // An invalid instruction only becomes a bubble when it would actually be loaded.
  assign w_bubble = flush | (~stall & ~id_valid);

  // All-zero bubble: aluop=add, no side effects, no forwarding matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= '0;
    end else if (w_bubble) begin
      r_ex <= '0;
    end else if (!stall) begin
      r_ex <= w_id;
    end
  end

  assign ex_valid    = r_ex.valid;
  assign ex_pc_plus4 = r_ex.pc_plus4;
  assign ex_rdata1   = r_ex.rdata1;
  assign ex_rdata2   = r_ex.rdata2;
  assign ex_imm      = r_ex.imm;
  assign ex_rs       = r_ex.rs;
  assign ex_rt       = r_ex.rt;
  assign ex_rd       = r_ex.rd;
  assign ex_funct    = r_ex.funct;
  assign ex_aluop    = r_ex.aluop;
  assign ex_alusrc   = r_ex.alusrc;
  assign ex_regdst   = r_ex.regdst;
  assign ex_branch   = r_ex.branch;
  assign ex_memread  = r_ex.memread;
  assign ex_memwrite = r_ex.memwrite;
  assign ex_memtoreg = r_ex.memtoreg;
  assign ex_regwrite = r_ex.regwrite;

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_count <= '0;
    end else if (w_bubble) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign bubble_count = r_bubble_count;
`else
  assign bubble_count = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized scoreboard bench for id_ex_reg: stimulus pushes expected EX state, a monitor pops and compares.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc;
    logic        regdst;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        regwrite;
  } bus_t;

  typedef struct packed {
    bus_t        ex;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  bus_t din = '0;
  bus_t dout;
  logic [31:0] bubble_count;

  logic        ex_valid, ex_alusrc, ex_regdst, ex_branch, ex_memread;
  logic        ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [31:0] ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [1:0]  ex_aluop;

  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];
  event chk_ev;

  bus_t        m_ex  = '0;
  int unsigned m_bub = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(din.valid), .id_pc_plus4(din.pc_plus4), .id_rdata1(din.rdata1),
    .id_rdata2(din.rdata2), .id_imm(din.imm), .id_rs(din.rs), .id_rt(din.rt),
    .id_rd(din.rd), .id_funct(din.funct), .id_aluop(din.aluop),
    .id_alusrc(din.alusrc), .id_regdst(din.regdst), .id_branch(din.branch),
    .id_memread(din.memread), .id_memwrite(din.memwrite),
    .id_memtoreg(din.memtoreg), .id_regwrite(din.regwrite),
    .ex_valid(ex_valid), .ex_pc_plus4(ex_pc_plus4), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_aluop(ex_aluop),
    .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .bubble_count(bubble_count)
  );

  always_comb begin
    dout = '0;
    dout.valid    = ex_valid;
    dout.pc_plus4 = ex_pc_plus4;
    dout.rdata1   = ex_rdata1;
    dout.rdata2   = ex_rdata2;
    dout.imm      = ex_imm;
    dout.rs       = ex_rs;
    dout.rt       = ex_rt;
    dout.rd       = ex_rd;
    dout.funct    = ex_funct;
    dout.aluop    = ex_aluop;
    dout.alusrc   = ex_alusrc;
    dout.regdst   = ex_regdst;
    dout.branch   = ex_branch;
    dout.memread  = ex_memread;
    dout.memwrite = ex_memwrite;
    dout.memtoreg = ex_memtoreg;
    dout.regwrite = ex_regwrite;
  end

  function automatic logic [31:0] exp_cnt();
`ifdef ID_EX_BUBBLE_COUNT_EN
    return m_bub;
`else
    return 32'h0;
`endif
  endfunction

  function automatic bus_t rnd_bus();
    bus_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.valid = ($urandom_range(7) != 0);
    return b;
  endfunction

  // Reference: a bubble is flush, or an invalid instruction arriving when not stalled.
  task automatic cycle(input logic r, input logic f, input logic s, input bus_t in);
    exp_t e;
    @(negedge clk);
    rst = r; flush = f; stall = s; din = in;
    if (r) begin
      m_ex = '0; m_bub = 0;
    end else if (f || (!s && !in.valid)) begin
      m_ex = '0; m_bub = m_bub + 1;
    end else if (!s) begin
      m_ex = in;
    end
    e.ex = m_ex; e.cnt = exp_cnt();
    sb_q.push_back(e);
  endtask

  // Raise reset mid-cycle and expect cleared outputs before the next edge.
  task automatic async_reset();
    exp_t e;
    bus_t b;
    @(negedge clk);
    b = rnd_bus();
    b.valid = 1'b1; b.aluop = 2'b11; b.regwrite = 1'b1; b.memwrite = 1'b1;
    flush = 1'b0; stall = 1'b0; din = b;
    #1 rst = 1'b1;
    m_ex = '0; m_bub = 0;
    e.ex = m_ex; e.cnt = exp_cnt();
    sb_q.push_back(e);
    -> chk_ev;
    #2;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        tests++;
        if (dout !== e.ex) begin
          fails++;
          $display("FAIL ex_bus t=%0t actual=%h required=%h", $time, dout, e.ex);
        end
        tests++;
        if (bubble_count !== e.cnt) begin
          fails++;
          $display("FAIL bubble_count t=%0t actual=%0d required=%0d", $time, bubble_count, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    bus_t b;
    bus_t nop;
    nop = '0;
    cycle(1'b1, 1'b0, 1'b0, rnd_bus());
    cycle(1'b1, 1'b0, 1'b0, rnd_bus());

    // R-type sub load
    b = '0;
    b.valid = 1'b1; b.aluop = 2'b10; b.funct = 6'b100010;
    b.rdata1 = 32'h7; b.rdata2 = 32'h3; b.regwrite = 1'b1; b.rd = 5'd9;
    cycle(1'b0, 1'b0, 1'b0, b);

    // lw, then three stalls with different inputs, then a new load
    b = '0;
    b.valid = 1'b1; b.aluop = 2'b00; b.memread = 1'b1; b.imm = 32'h10;
    b.alusrc = 1'b1; b.memtoreg = 1'b1; b.regwrite = 1'b1; b.rt = 5'd4;
    cycle(1'b0, 1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, rnd_bus());
    b = rnd_bus(); b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);

    // sw held in EX, then flush+stall together
    b = '0;
    b.valid = 1'b1; b.memwrite = 1'b1; b.alusrc = 1'b1; b.rs = 5'd2; b.rt = 5'd5;
    cycle(1'b0, 1'b0, 1'b0, b);
    cycle(1'b0, 1'b1, 1'b1, rnd_bus());

    // invalid load carrying write controls
    b = rnd_bus(); b.valid = 1'b0; b.regwrite = 1'b1; b.memwrite = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    // invalid instruction during stall is held, not bubbled
    b = rnd_bus(); b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    b = rnd_bus(); b.valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, b);

    // counter pattern from a fresh reset: 2 flushes, 3 stalls, 1 invalid load
    cycle(1'b1, 1'b0, 1'b0, nop);
    b = rnd_bus(); b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);
    cycle(1'b0, 1'b1, 1'b0, rnd_bus());
    cycle(1'b0, 1'b1, 1'b0, rnd_bus());
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, rnd_bus());
    b = rnd_bus(); b.valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, b);

    // asynchronous reset between edges, then release into a normal load
    async_reset();
    b = rnd_bus(); b.valid = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, b);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(7) == 0),
            ($urandom_range(3) == 0), rnd_bus());
    end

    cycle(1'b0, 1'b0, 1'b1, rnd_bus());
    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
